// File: rtl/drp_trace_pkg.sv
// rtl/drp_trace_pkg.sv - shared record layout, frame format, mode and FSM encodings
package drp_trace_pkg;

  localparam int REC_W        = 40;
  localparam int REC_WE_BIT   = 39;
  localparam int REC_TO_BIT   = 38;
  localparam int REC_LAT_LSB  = 32;
  localparam int REC_LAT_W    = 6;
  localparam int REC_ADDR_LSB = 16;
  localparam int REC_DATA_LSB = 0;

  localparam int         FRAME_LEN  = 6;
  localparam logic [7:0] FRAME_TERM = 8'h0A;

  localparam logic [1:0] MODE_OFF = 2'b00;
  localparam logic [1:0] MODE_WR  = 2'b01;
  localparam logic [1:0] MODE_RD  = 2'b10;
  localparam logic [1:0] MODE_ALL = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } drp_state_t;

  // Byte idx of the outgoing frame for a record, most significant field first.
  function automatic logic [7:0] frame_byte(input logic [REC_W-1:0] rec, input logic [2:0] idx);
    logic [7:0] b;
    case (idx)
      3'd0:    b = rec[REC_LAT_LSB +: 8];
      3'd1:    b = rec[REC_ADDR_LSB + 8 +: 8];
      3'd2:    b = rec[REC_ADDR_LSB +: 8];
      3'd3:    b = rec[REC_DATA_LSB + 8 +: 8];
      3'd4:    b = rec[REC_DATA_LSB +: 8];
      default: b = FRAME_TERM;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/drp_trace_fifo.sv
// rtl/drp_trace_fifo.sv - trace record FIFO with extra-MSB pointers and first-word read-through
module drp_trace_fifo
  import drp_trace_pkg::*;
#(
  parameter int C_WIDTH = REC_W,
  parameter int C_DEPTH = 16
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_wr_en,
  input  logic [C_WIDTH-1:0] i_wdata,
  input  logic               i_rd_en,
  output logic [C_WIDTH-1:0] o_rdata,
  output logic               o_full,
  output logic               o_empty
);

  localparam int AW = $clog2(C_DEPTH);

  logic [C_WIDTH-1:0] r_mem [C_DEPTH];
  logic [AW:0]        r_wptr;
  logic [AW:0]        r_rptr;
  logic               w_wr;
  logic               w_rd;

  assign o_empty = (r_wptr == r_rptr);
  assign o_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign o_rdata = r_mem[r_rptr[AW-1:0]];

  // A full FIFO still takes a write when a read frees a slot in the same cycle.
  assign w_rd = i_rd_en && !o_empty;
  assign w_wr = i_wr_en && (!o_full || w_rd);

  always_ff @(posedge i_clk) begin
    if (w_wr) r_mem[r_wptr[AW-1:0]] <= i_wdata;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_wr) r_wptr <= r_wptr + 1'b1;
      if (w_rd) r_rptr <= r_rptr + 1'b1;
    end
  end

endmodule

// File: rtl/drp_trace_mon.sv
// rtl/drp_trace_mon.sv - DRP pass-through monitor tracing filtered transactions to a byte stream
module drp_trace_mon
  import drp_trace_pkg::*;
#(
  parameter int C_ADDR_WIDTH = 12,
  parameter int C_DATA_WIDTH = 16,
  parameter int C_FIFO_DEPTH = 16,
  parameter int C_TIMEOUT    = 1023
) (
  input  logic                    DRPCLK_I,
  input  logic                    DRPRSTN_I,
  input  logic [C_ADDR_WIDTH-1:0] S_DRPADDR_I,
  input  logic [C_DATA_WIDTH-1:0] S_DRPDI_I,
  output logic [C_DATA_WIDTH-1:0] S_DRPDO_O,
  input  logic                    S_DRPEN_I,
  input  logic                    S_DRPWE_I,
  output logic                    S_DRPRDY_O,
  output logic [C_ADDR_WIDTH-1:0] M_DRPADDR_O,
  output logic [C_DATA_WIDTH-1:0] M_DRPDI_O,
  input  logic [C_DATA_WIDTH-1:0] M_DRPDO_I,
  output logic                    M_DRPEN_O,
  output logic                    M_DRPWE_O,
  input  logic                    M_DRPRDY_I,
  input  logic [1:0]              CFG_MODE_I,
  input  logic [C_ADDR_WIDTH-1:0] CFG_ADDR_LO_I,
  input  logic [C_ADDR_WIDTH-1:0] CFG_ADDR_HI_I,
  output logic [15:0]             OVF_CNT_O,
  output logic                    TIMEOUT_O,
  output logic                    PROTO_ERR_O,
  output logic [7:0]              TRC_TDATA_O,
  output logic                    TRC_TVALID_O,
  input  logic                    TRC_TREADY_I
);

  logic [1:0]              r_rst_sync;
  logic                    w_rstn;
  drp_state_t              r_state;
  logic [C_ADDR_WIDTH-1:0] r_addr;
  logic [C_DATA_WIDTH-1:0] r_di;
  logic [C_DATA_WIDTH-1:0] r_do;
  logic                    r_we;
  logic                    r_to;
  logic [15:0]             r_lat;
  logic                    r_s_rdy;
  logic                    r_m_en;
  logic                    r_m_we;
  logic                    r_timeout_p;
  logic                    r_proto_err;
  logic [15:0]             r_ovf_cnt;
  logic [2:0]              r_byte_idx;

  logic [REC_LAT_W-1:0]    w_lat6;
  logic [REC_W-1:0]        w_rec;
  logic [REC_W-1:0]        w_rdata;
  logic                    w_mode_hit;
  logic                    w_win_hit;
  logic                    w_push;
  logic                    w_pop;
  logic                    w_full;
  logic                    w_empty;
  logic                    w_drop;
  logic                    w_fire;
  logic                    w_last;

  // Assertion is immediate; release waits two clock edges.
  always_ff @(posedge DRPCLK_I or negedge DRPRSTN_I) begin
    if (!DRPRSTN_I) r_rst_sync <= 2'b00;
    else            r_rst_sync <= {r_rst_sync[0], 1'b1};
  end
  assign w_rstn = r_rst_sync[1];

  always_ff @(posedge DRPCLK_I or negedge w_rstn) begin
    if (!w_rstn) begin
      r_state     <= ST_IDLE;
      r_addr      <= '0;
      r_di        <= '0;
      r_do        <= '0;
      r_we        <= 1'b0;
      r_to        <= 1'b0;
      r_lat       <= '0;
      r_s_rdy     <= 1'b0;
      r_m_en      <= 1'b0;
      r_m_we      <= 1'b0;
      r_timeout_p <= 1'b0;
      r_proto_err <= 1'b0;
    end else begin
      r_s_rdy     <= 1'b0;
      r_m_en      <= 1'b0;
      r_m_we      <= 1'b0;
      r_timeout_p <= 1'b0;
      if (S_DRPEN_I && (r_state != ST_IDLE)) r_proto_err <= 1'b1;
      case (r_state)
        ST_IDLE: begin
          if (S_DRPEN_I) begin
            r_addr  <= S_DRPADDR_I;
            r_di    <= S_DRPDI_I;
            r_we    <= S_DRPWE_I;
            r_lat   <= '0;
            r_m_en  <= 1'b1;
            r_m_we  <= S_DRPWE_I;
            r_state <= ST_ISSUE;
          end
        end
        ST_ISSUE: r_state <= ST_WAIT;
        ST_WAIT: begin
          r_lat <= r_lat + 16'd1;
          if (M_DRPRDY_I) begin
            r_do    <= M_DRPDO_I;
            r_to    <= 1'b0;
            r_s_rdy <= 1'b1;
            r_state <= ST_DONE;
          end else if ((r_lat + 16'd1) == 16'(C_TIMEOUT)) begin
            r_do        <= '1;
            r_to        <= 1'b1;
            r_timeout_p <= 1'b1;
            r_s_rdy     <= 1'b1;
            r_state     <= ST_DONE;
          end
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign S_DRPDO_O   = r_do;
  assign S_DRPRDY_O  = r_s_rdy;
  assign M_DRPADDR_O = r_addr;
  assign M_DRPDI_O   = r_di;
  assign M_DRPEN_O   = r_m_en;
  assign M_DRPWE_O   = r_m_we;
  assign TIMEOUT_O   = r_timeout_p;
  assign PROTO_ERR_O = r_proto_err;
  assign OVF_CNT_O   = r_ovf_cnt;

  assign w_lat6 = (r_lat > 16'd63) ? 6'd63 : r_lat[REC_LAT_W-1:0];

  always_comb begin
    w_rec                              = '0;
    w_rec[REC_WE_BIT]                  = r_we;
    w_rec[REC_TO_BIT]                  = r_to;
    w_rec[REC_LAT_LSB +: REC_LAT_W]    = w_lat6;
    w_rec[REC_ADDR_LSB +: 16]          = 16'(r_addr);
    w_rec[REC_DATA_LSB +: 16]          = 16'(r_we ? r_di : r_do);
  end

  // An inverted window (LO > HI) can never satisfy both bounds, so it passes nothing.
  assign w_mode_hit = r_we ? |(CFG_MODE_I & MODE_WR) : |(CFG_MODE_I & MODE_RD);
  assign w_win_hit  = (r_addr >= CFG_ADDR_LO_I) && (r_addr <= CFG_ADDR_HI_I);
  assign w_push     = (r_state == ST_DONE) && w_mode_hit && w_win_hit;
  assign w_drop     = w_push && w_full && !w_pop;

  always_ff @(posedge DRPCLK_I or negedge w_rstn) begin
    if (!w_rstn)                                r_ovf_cnt <= '0;
    else if (w_drop && (r_ovf_cnt != 16'hFFFF)) r_ovf_cnt <= r_ovf_cnt + 16'd1;
  end

  drp_trace_fifo #(
    .C_WIDTH (REC_W),
    .C_DEPTH (C_FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (DRPCLK_I),
    .i_rst_n (w_rstn),
    .i_wr_en (w_push),
    .i_wdata (w_rec),
    .i_rd_en (w_pop),
    .o_rdata (w_rdata),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // The head record is the one on the wire; it leaves the FIFO only once its terminator
  // is accepted, so every slot including the frame in flight counts toward capacity.
  assign TRC_TVALID_O = !w_empty;
  assign TRC_TDATA_O  = w_empty ? 8'h00 : frame_byte(w_rdata, r_byte_idx);
  assign w_fire       = TRC_TVALID_O && TRC_TREADY_I;
  assign w_last       = (r_byte_idx == 3'(FRAME_LEN - 1));
  assign w_pop        = w_fire && w_last;

  always_ff @(posedge DRPCLK_I or negedge w_rstn) begin
    if (!w_rstn)     r_byte_idx <= '0;
    else if (w_fire) r_byte_idx <= w_last ? 3'd0 : r_byte_idx + 3'd1;
  end

endmodule

// File: tb/tb_drp_trace_mon.sv
// tb/tb_drp_trace_mon.sv - directed self-checking bench for drp_trace_mon
module tb_drp_trace_mon;
  import drp_trace_pkg::*;

  localparam int AW    = 12;
  localparam int DW    = 16;
  localparam int DEPTH = 16;
  localparam int TMO   = 8;

  logic          DRPCLK_I = 1'b0;
  logic          DRPRSTN_I = 1'b0;
  logic [AW-1:0] S_DRPADDR_I = '0;
  logic [DW-1:0] S_DRPDI_I = '0;
  logic [DW-1:0] S_DRPDO_O;
  logic          S_DRPEN_I = 1'b0;
  logic          S_DRPWE_I = 1'b0;
  logic          S_DRPRDY_O;
  logic [AW-1:0] M_DRPADDR_O;
  logic [DW-1:0] M_DRPDI_O;
  logic [DW-1:0] M_DRPDO_I = '0;
  logic          M_DRPEN_O;
  logic          M_DRPWE_O;
  logic          M_DRPRDY_I = 1'b0;
  logic [1:0]    CFG_MODE_I = 2'b11;
  logic [AW-1:0] CFG_ADDR_LO_I = '0;
  logic [AW-1:0] CFG_ADDR_HI_I = 12'hFFF;
  logic [15:0]   OVF_CNT_O;
  logic          TIMEOUT_O;
  logic          PROTO_ERR_O;
  logic [7:0]    TRC_TDATA_O;
  logic          TRC_TVALID_O;
  logic          TRC_TREADY_I = 1'b1;

  drp_trace_mon #(
    .C_ADDR_WIDTH (AW),
    .C_DATA_WIDTH (DW),
    .C_FIFO_DEPTH (DEPTH),
    .C_TIMEOUT    (TMO)
  ) dut (
    .DRPCLK_I      (DRPCLK_I),
    .DRPRSTN_I     (DRPRSTN_I),
    .S_DRPADDR_I   (S_DRPADDR_I),
    .S_DRPDI_I     (S_DRPDI_I),
    .S_DRPDO_O     (S_DRPDO_O),
    .S_DRPEN_I     (S_DRPEN_I),
    .S_DRPWE_I     (S_DRPWE_I),
    .S_DRPRDY_O    (S_DRPRDY_O),
    .M_DRPADDR_O   (M_DRPADDR_O),
    .M_DRPDI_O     (M_DRPDI_O),
    .M_DRPDO_I     (M_DRPDO_I),
    .M_DRPEN_O     (M_DRPEN_O),
    .M_DRPWE_O     (M_DRPWE_O),
    .M_DRPRDY_I    (M_DRPRDY_I),
    .CFG_MODE_I    (CFG_MODE_I),
    .CFG_ADDR_LO_I (CFG_ADDR_LO_I),
    .CFG_ADDR_HI_I (CFG_ADDR_HI_I),
    .OVF_CNT_O     (OVF_CNT_O),
    .TIMEOUT_O     (TIMEOUT_O),
    .PROTO_ERR_O   (PROTO_ERR_O),
    .TRC_TDATA_O   (TRC_TDATA_O),
    .TRC_TVALID_O  (TRC_TVALID_O),
    .TRC_TREADY_I  (TRC_TREADY_I)
  );

  always #5 DRPCLK_I = ~DRPCLK_I;

  int         n_checks = 0;
  int         n_errors = 0;
  int         cycle = 0;
  int         men_cnt = 0;
  int         to_cnt = 0;
  int         s_rdy_cnt = 0;
  logic [7:0] bq[$];
  int         tq[$];

  always @(posedge DRPCLK_I) cycle++;

  always @(negedge DRPCLK_I) begin
    if (M_DRPEN_O)  men_cnt++;
    if (TIMEOUT_O)  to_cnt++;
    if (S_DRPRDY_O) s_rdy_cnt++;
  end

  always @(negedge DRPCLK_I) begin
    #1;
    if (TRC_TVALID_O && TRC_TREADY_I) begin
      bq.push_back(TRC_TDATA_O);
      tq.push_back(cycle);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [47:0] got, input logic [47:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_stream();
    bq.delete();
    tq.delete();
  endtask

  task automatic check_frame(input string tag, input logic [47:0] exp);
    logic [47:0] got;
    got = '0;
    for (int k = 0; k < 200 && bq.size() < 6; k++) @(negedge DRPCLK_I);
    if (bq.size() < 6) begin
      check_eq({tag, "_bytes"}, 48'(bq.size()), 48'd6);
    end else begin
      for (int b = 0; b < 6; b++) begin
        got = {got[39:0], bq.pop_front()};
        void'(tq.pop_front());
      end
      check_eq(tag, got, exp);
    end
  endtask

  // Drives one slave transaction; the master side answers on the cycle after M_DRPEN_O
  // when respond is set. cyc counts cycles from S_DRPEN_I until S_DRPRDY_O is seen.
  task automatic drp_xfer(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] di,
                          input logic respond, input logic [DW-1:0] rdo, input logic poke,
                          output int cyc, output logic [DW-1:0] dout);
    @(negedge DRPCLK_I);
    S_DRPEN_I = 1'b1; S_DRPWE_I = we; S_DRPADDR_I = addr; S_DRPDI_I = di; M_DRPDO_I = rdo;
    cyc = 0;
    dout = '0;
    for (int k = 0; k < 40; k++) begin
      @(negedge DRPCLK_I);
      cyc++;
      if (S_DRPRDY_O) begin
        dout = S_DRPDO_O;
        break;
      end
      if (cyc == 1) begin
        check_eq("issue", 48'({M_DRPEN_O, M_DRPWE_O, M_DRPADDR_O, M_DRPDI_O}),
                 48'({1'b1, we, addr, di}));
        S_DRPEN_I = 1'b0; S_DRPWE_I = 1'b0;
      end
      if (cyc == 2) begin
        M_DRPRDY_I = respond; S_DRPEN_I = poke;
      end
      if (cyc == 3) begin
        M_DRPRDY_I = 1'b0; S_DRPEN_I = 1'b0;
      end
    end
    M_DRPRDY_I = 1'b0; S_DRPEN_I = 1'b0;
  endtask

  int            cyc;
  int            m0;
  int            t0;
  int            r0;
  logic [DW-1:0] dout;

  initial begin
    repeat (3) @(negedge DRPCLK_I);
    DRPRSTN_I = 1'b1;
    repeat (3) @(negedge DRPCLK_I);
    check_eq("rst_s_side", 48'({S_DRPRDY_O, S_DRPDO_O}), 48'd0);
    check_eq("rst_m_side", 48'({M_DRPEN_O, M_DRPWE_O, M_DRPADDR_O, M_DRPDI_O}), 48'd0);
    check_eq("rst_status", 48'({OVF_CNT_O, TIMEOUT_O, PROTO_ERR_O, TRC_TVALID_O, TRC_TDATA_O}), 48'd0);

    // Single-cycle-response write: minimum latency and first frame.
    m0 = men_cnt;
    drp_xfer(1'b1, 12'h012, 16'hBEEF, 1'b1, 16'h1234, 1'b0, cyc, dout);
    check_eq("wr_latency", 48'(cyc), 48'd3);
    check_eq("wr_dout", 48'(dout), 48'h1234);
    check_eq("wr_men_pulses", 48'(men_cnt - m0), 48'd1);
    check_frame("wr_frame", 48'h81_00_12_BE_EF_0A);

    drp_xfer(1'b0, 12'h2AB, 16'h0000, 1'b1, 16'hA5C3, 1'b0, cyc, dout);
    check_eq("rd_dout", 48'(dout), 48'hA5C3);
    check_frame("rd_frame", 48'h01_02_AB_A5_C3_0A);

    // Timeout on a read, then a late ready that must be ignored.
    t0 = to_cnt;
    drp_xfer(1'b0, 12'h034, 16'h0000, 1'b0, 16'h0000, 1'b0, cyc, dout);
    check_eq("to_latency", 48'(cyc), 48'd10);
    check_eq("to_dout", 48'(dout), 48'hFFFF);
    @(negedge DRPCLK_I);
    check_eq("to_pulses", 48'(to_cnt - t0), 48'd1);
    check_frame("to_frame", 48'h48_00_34_FF_FF_0A);
    r0 = s_rdy_cnt;
    M_DRPDO_I = 16'h7777; M_DRPRDY_I = 1'b1;
    @(negedge DRPCLK_I);
    M_DRPRDY_I = 1'b0;
    repeat (3) @(negedge DRPCLK_I);
    check_eq("late_rdy_dout", 48'(S_DRPDO_O), 48'hFFFF);
    check_eq("late_rdy_srdy", 48'(s_rdy_cnt - r0), 48'd0);

    // Writes-only filter on 0x10..0x1F.
    CFG_MODE_I = 2'b01; CFG_ADDR_LO_I = 12'h010; CFG_ADDR_HI_I = 12'h01F;
    drp_xfer(1'b1, 12'h005, 16'h1111, 1'b1, 16'h0, 1'b0, cyc, dout);
    drp_xfer(1'b1, 12'h015, 16'h5A5A, 1'b1, 16'h0, 1'b0, cyc, dout);
    drp_xfer(1'b0, 12'h015, 16'h0000, 1'b1, 16'h3C3C, 1'b0, cyc, dout);
    repeat (20) @(negedge DRPCLK_I);
    check_eq("flt_wr_count", 48'(bq.size()), 48'd6);
    check_frame("flt_wr_frame", 48'h81_00_15_5A_5A_0A);

    // Window bounds are inclusive.
    CFG_MODE_I = 2'b11;
    drp_xfer(1'b1, 12'h00F, 16'h0F0F, 1'b1, 16'h0, 1'b0, cyc, dout);
    drp_xfer(1'b0, 12'h010, 16'h0000, 1'b1, 16'h1111, 1'b0, cyc, dout);
    drp_xfer(1'b1, 12'h01F, 16'h2222, 1'b1, 16'h0, 1'b0, cyc, dout);
    drp_xfer(1'b0, 12'h020, 16'h0000, 1'b1, 16'h3333, 1'b0, cyc, dout);
    check_frame("win_lo_frame", 48'h01_00_10_11_11_0A);
    check_frame("win_hi_frame", 48'h81_00_1F_22_22_0A);
    repeat (10) @(negedge DRPCLK_I);
    check_eq("win_extra", 48'(bq.size()), 48'd0);

    CFG_ADDR_LO_I = 12'h020; CFG_ADDR_HI_I = 12'h010;
    drp_xfer(1'b1, 12'h015, 16'h4444, 1'b1, 16'h0, 1'b0, cyc, dout);
    CFG_MODE_I = 2'b00; CFG_ADDR_LO_I = 12'h000; CFG_ADDR_HI_I = 12'hFFF;
    drp_xfer(1'b1, 12'h015, 16'h4444, 1'b1, 16'h0, 1'b0, cyc, dout);
    repeat (20) @(negedge DRPCLK_I);
    check_eq("inv_win_mode_off", 48'(bq.size()), 48'd0);

    // Enable during WAIT is a protocol error and issues nothing.
    CFG_MODE_I = 2'b11;
    check_eq("proto_before", 48'(PROTO_ERR_O), 48'd0);
    m0 = men_cnt;
    drp_xfer(1'b0, 12'h040, 16'h0000, 1'b1, 16'h0404, 1'b1, cyc, dout);
    repeat (4) @(negedge DRPCLK_I);
    check_eq("proto_err", 48'(PROTO_ERR_O), 48'd1);
    check_eq("proto_men_pulses", 48'(men_cnt - m0), 48'd1);
    repeat (20) @(negedge DRPCLK_I);
    clear_stream();

    // Stalled stream: 16 records fill the FIFO, the 17th is dropped.
    TRC_TREADY_I = 1'b0;
    for (int i = 0; i < 17; i++)
      drp_xfer(1'b1, 12'(i), 16'(16'h1000 + i), 1'b1, 16'h0, 1'b0, cyc, dout);
    repeat (2) @(negedge DRPCLK_I);
    check_eq("ovf_cnt", 48'(OVF_CNT_O), 48'd1);
    check_eq("stall_head", 48'({TRC_TVALID_O, TRC_TDATA_O}), 48'h1_81);
    repeat (5) @(negedge DRPCLK_I);
    check_eq("stall_stable", 48'({TRC_TVALID_O, TRC_TDATA_O}), 48'h1_81);
    TRC_TREADY_I = 1'b1;
    for (int k = 0; k < 400 && bq.size() < 96; k++) @(negedge DRPCLK_I);
    check_eq("drain_bytes", 48'(bq.size()), 48'd96);
    if (bq.size() >= 96) begin
      check_eq("back_to_back", 48'(tq[95] - tq[0]), 48'd95);
      for (int i = 0; i < 16; i++)
        check_frame($sformatf("drain_frame%0d", i), {8'h81, 8'h00, 8'(i), 8'h10, 8'(i), 8'h0A});
    end
    repeat (10) @(negedge DRPCLK_I);
    check_eq("drain_extra", 48'(bq.size()), 48'd0);

    // Reset in the middle of WAIT with a frame pending and sticky state set.
    TRC_TREADY_I = 1'b0;
    drp_xfer(1'b1, 12'h077, 16'hCAFE, 1'b1, 16'h4321, 1'b0, cyc, dout);
    check_eq("pre_rst_dout", 48'(dout), 48'h4321);
    @(negedge DRPCLK_I);
    S_DRPEN_I = 1'b1; S_DRPWE_I = 1'b0; S_DRPADDR_I = 12'h055;
    @(negedge DRPCLK_I);
    S_DRPEN_I = 1'b0;
    repeat (2) @(negedge DRPCLK_I);
    r0 = s_rdy_cnt;
    DRPRSTN_I = 1'b0;
    #1;
    check_eq("rst_mid_dout", 48'({S_DRPRDY_O, S_DRPDO_O}), 48'd0);
    check_eq("rst_mid_m_side", 48'({M_DRPEN_O, M_DRPWE_O, M_DRPADDR_O, M_DRPDI_O}), 48'd0);
    check_eq("rst_mid_status", 48'({OVF_CNT_O, TIMEOUT_O, PROTO_ERR_O, TRC_TVALID_O, TRC_TDATA_O}), 48'd0);
    repeat (3) @(negedge DRPCLK_I);
    DRPRSTN_I = 1'b1;
    TRC_TREADY_I = 1'b1;
    clear_stream();
    repeat (20) @(negedge DRPCLK_I);
    check_eq("rst_no_srdy", 48'(s_rdy_cnt - r0), 48'd0);
    check_eq("rst_no_record", 48'({TRC_TVALID_O, 8'(bq.size())}), 48'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
